// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_pkg
//  Description : Shared definitions for the iterative RV32M multiply/divide
//                sequencer: funct3 operation codes, FSM state type and
//                operand signedness helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_seq_pkg;

    // M-extension funct3 operation codes
    localparam logic [2:0] c_md_mul    = 3'b000;
    localparam logic [2:0] c_md_mulh   = 3'b001;
    localparam logic [2:0] c_md_mulhsu = 3'b010;
    localparam logic [2:0] c_md_mulhu  = 3'b011;
    localparam logic [2:0] c_md_div    = 3'b100;
    localparam logic [2:0] c_md_divu   = 3'b101;
    localparam logic [2:0] c_md_rem    = 3'b110;
    localparam logic [2:0] c_md_remu   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input logic [2:0] funct3);
        logic s;
        case (funct3)
            c_md_mul, c_md_mulh, c_md_mulhsu, c_md_div, c_md_rem: s = 1'b1;
            default:                                              s = 1'b0;
        endcase
        return s;
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM
    function automatic logic op_b_signed(input logic [2:0] funct3);
        logic s;
        case (funct3)
            c_md_mul, c_md_mulh, c_md_div, c_md_rem: s = 1'b1;
            default:                                 s = 1'b0;
        endcase
        return s;
    endfunction

    // funct3[2] separates the divide family from the multiply family
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage : muldiv_seq_pkg
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_if
//  Description : Execute-stage <-> multiply/divide sequencer interface.
//                slave  : the sequencer (receives requests, drives results)
//                master : execute / hazard logic (drives requests)
//  Signals     : start_i, funct3_i, op_a_i, op_b_i, rd_addr_i, flush_i
//                (requests), busy_o, stall_e_o, valid_o, result_o, rd_addr_o
//                (responses)
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_seq_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      start_i;
    logic [2:0]                funct3_i;
    logic [DATA_WIDTH-1:0]     op_a_i;
    logic [DATA_WIDTH-1:0]     op_b_i;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_i;
    logic                      flush_i;
    logic                      busy_o;
    logic                      stall_e_o;
    logic                      valid_o;
    logic [DATA_WIDTH-1:0]     result_o;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_o;

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, rd_addr_i, flush_i,
        output busy_o, stall_e_o, valid_o, result_o, rd_addr_o
    );

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, rd_addr_i, flush_i,
        input  busy_o, stall_e_o, valid_o, result_o, rd_addr_o
    );
endinterface : muldiv_seq_if
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One iteration of the sequencer datapath (combinational).
//                Multiply mode: shift-add.  acc = {hi, lo}, lo holds the
//                  remaining multiplier bits; if lo[0] the multiplicand is
//                  added to hi, then the whole W+1+W-1 result shifts right.
//                Divide mode: restoring subtract. acc = {rem, dividend/quot};
//                  the pair shifts left one bit, the divisor is trial-
//                  subtracted from the remainder and the quotient bit enters
//                  at lo[0].
//  Ports       : i_acc      2*DATA_WIDTH accumulator in
//                i_operand  multiplicand (mul) or divisor (div) magnitude
//                i_div_mode 1 = divide step, 0 = multiply step
//                o_acc      next accumulator
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [2*DATA_WIDTH-1:0] i_acc,
    input  wire logic [DATA_WIDTH-1:0]   i_operand,
    input  wire logic                    i_div_mode,
    output logic      [2*DATA_WIDTH-1:0] o_acc
);

    logic [DATA_WIDTH-1:0] w_hi;
    logic [DATA_WIDTH-1:0] w_lo;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_trial;
    logic [DATA_WIDTH:0]   w_diff;

    always_comb begin
        w_hi    = i_acc[2*DATA_WIDTH-1:DATA_WIDTH];
        w_lo    = i_acc[DATA_WIDTH-1:0];

        // Multiply: keep the carry so the shifted-in MSB is exact
        w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_operand} : '0);

        // Divide: the partial remainder is always < divisor, so the shifted
        // trial value fits in W+1 bits and the subtract's MSB is the borrow.
        w_trial = {w_hi, w_lo[DATA_WIDTH-1]};
        w_diff  = w_trial - {1'b0, i_operand};

        o_acc   = {w_sum, w_lo[DATA_WIDTH-1:1]};
        if (i_div_mode) begin
            if (!w_diff[DATA_WIDTH]) begin
                o_acc = {w_diff[DATA_WIDTH-1:0], w_lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_trial[DATA_WIDTH-1:0], w_lo[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer beside the EX ALU.
//                Accepts one M-op in IDLE/DONE, stalls execute while it
//                iterates (DATA_WIDTH steps), fixes up signs in FIX and
//                presents a one-cycle result strobe in DONE. Divide-by-zero
//                and signed overflow bypass iteration. A flush aborts the op.
//  Ports       : clk, rst (async, active-high)
//                bus (muldiv_seq_if.slave):
//                  start_i, funct3_i, op_a_i, op_b_i, rd_addr_i, flush_i
//                  busy_o, stall_e_o, valid_o, result_o, rd_addr_o
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    muldiv_seq_if.slave bus
);

    localparam int                    c_cnt_w   = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_min_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    muldiv_state_e               state_q,   state_d;
    logic [c_cnt_w-1:0]          cnt_q,     cnt_d;
    logic [2*DATA_WIDTH-1:0]     acc_q,     acc_d;
    logic [DATA_WIDTH-1:0]       opnd_q,    opnd_d;     // multiplicand or divisor magnitude
    logic [2:0]                  funct3_q,  funct3_d;
    logic                        neg_q,     neg_d;      // product/quotient negate
    logic                        rem_neg_q, rem_neg_d;  // remainder follows dividend sign
    logic [REG_ADDR_WIDTH-1:0]   rd_q,      rd_d;
    logic [DATA_WIDTH-1:0]       result_q,  result_d;
    logic                        valid_q,   valid_d;

    // ------------------------------------------------------------------
    // Request decode and magnitude conversion
    // ------------------------------------------------------------------
    logic                  w_idle_done;
    logic                  w_busy;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_div_zero;
    logic                  w_div_ovf;

    always_comb begin
        w_idle_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
        w_busy      = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);

        w_a_neg     = op_a_signed(bus.funct3_i) & bus.op_a_i[DATA_WIDTH-1];
        w_b_neg     = op_b_signed(bus.funct3_i) & bus.op_b_i[DATA_WIDTH-1];
        w_a_mag     = w_a_neg ? (~bus.op_a_i + 1'b1) : bus.op_a_i;
        w_b_mag     = w_b_neg ? (~bus.op_b_i + 1'b1) : bus.op_b_i;

        w_div_zero  = (bus.op_b_i == '0);
        // Only the signed divide/remainder can overflow (MIN / -1)
        w_div_ovf   = ((bus.funct3_i == c_md_div) || (bus.funct3_i == c_md_rem)) &&
                      (bus.op_a_i == c_min_neg) && (&bus.op_b_i);
    end

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] w_step_acc;

    muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .i_acc      (acc_q),
        .i_operand  (opnd_q),
        .i_div_mode (state_q == ST_DIV),
        .o_acc      (w_step_acc)
    );

    // ------------------------------------------------------------------
    // Sign fix-up and result selection
    // ------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_quot;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [DATA_WIDTH-1:0]   w_fix_result;

    always_comb begin
        w_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        w_quot = neg_q ? (~acc_q[DATA_WIDTH-1:0] + 1'b1) : acc_q[DATA_WIDTH-1:0];
        w_rem  = rem_neg_q ? (~acc_q[2*DATA_WIDTH-1:DATA_WIDTH] + 1'b1)
                           : acc_q[2*DATA_WIDTH-1:DATA_WIDTH];

        case (funct3_q)
            c_md_mul:                          w_fix_result = w_prod[DATA_WIDTH-1:0];
            c_md_mulh, c_md_mulhsu, c_md_mulhu: w_fix_result = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            c_md_div, c_md_divu:               w_fix_result = w_quot;
            default:                           w_fix_result = w_rem;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        funct3_d  = funct3_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        rd_d      = rd_q;
        result_d  = result_q;
        valid_d   = 1'b0;

        if (bus.flush_i) begin
            // Abort wins over everything, including a same-cycle start
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (bus.start_i) begin
                        funct3_d  = bus.funct3_i;
                        rd_d      = bus.rd_addr_i;
                        neg_d     = w_a_neg ^ w_b_neg;
                        rem_neg_d = w_a_neg;
                        cnt_d     = c_cnt_w'(DATA_WIDTH - 1);
                        if (is_div_op(bus.funct3_i)) begin
                            if (w_div_zero) begin
                                // funct3[1] selects REM/REMU
                                result_d = bus.funct3_i[1] ? bus.op_a_i : '1;
                                valid_d  = 1'b1;
                                state_d  = ST_DONE;
                            end else if (w_div_ovf) begin
                                result_d = bus.funct3_i[1] ? '0 : c_min_neg;
                                valid_d  = 1'b1;
                                state_d  = ST_DONE;
                            end else begin
                                acc_d   = {{DATA_WIDTH{1'b0}}, w_a_mag};
                                opnd_d  = w_b_mag;
                                state_d = ST_DIV;
                            end
                        end else begin
                            acc_d   = {{DATA_WIDTH{1'b0}}, w_b_mag};
                            opnd_d  = w_a_mag;
                            state_d = ST_MUL;
                        end
                    end
                end

                ST_MUL, ST_DIV: begin
                    acc_d = w_step_acc;
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                ST_FIX: begin
                    result_d = w_fix_result;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            funct3_q  <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            funct3_q  <= funct3_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy_o    = w_busy;
    // Drops in DONE (unless a new op is being accepted) so execute advances
    assign bus.stall_e_o = (bus.start_i & w_idle_done & ~bus.flush_i) | w_busy;
    assign bus.valid_o   = valid_q;
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_q;

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Directed, table-driven bench for muldiv_seq with hand-
//                written sequences for flush, back-to-back and reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_seq_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    muldiv_seq #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int lat, input string name);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a negedge; the op is accepted at the
    // next posedge (E0). Latency counts negedges after E0 until valid_o.
    task automatic apply(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                         input string tag);
        int lat;
        bit stall_ok;
        bus.start_i   = 1'b1;
        bus.funct3_i  = f;
        bus.op_a_i    = a;
        bus.op_b_i    = b;
        bus.rd_addr_i = rd;
        bus.flush_i   = 1'b0;
        #1;
        chk({tag, "_stall_req"}, 32'(bus.stall_e_o), 32'd1);
        @(posedge clk);
        #1;
        bus.start_i   = 1'b0;
        bus.op_a_i    = 32'hDEADBEEF;
        bus.op_b_i    = 32'h0BADF00D;
        bus.rd_addr_i = ~rd;
        lat      = 0;
        stall_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                lat = k;
                break;
            end
            if (!bus.stall_e_o) stall_ok = 1'b0;
        end
        chk({tag, "_latency"},   32'(lat),             32'(exp_lat));
        chk({tag, "_result"},    bus.result_o,          exp_res);
        chk({tag, "_rd"},        32'(bus.rd_addr_o),    32'(rd));
        chk({tag, "_stall_low"}, 32'(bus.stall_e_o),    32'd0);
        chk({tag, "_stall_hi"},  32'(stall_ok),         32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen;

        vecs.push_back(mk(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3"));
        vecs.push_back(mk(MUL,    32'h12345678, 32'h00000010, 32'h23456780, 34, "mul_shift"));
        vecs.push_back(mk(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min"));
        vecs.push_back(mk(MULH,   32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 34, "mulh_neg"));
        vecs.push_back(mk(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max"));
        vecs.push_back(mk(MULHU,  32'h80000000, 32'd4,        32'h00000002, 34, "mulhu_pow2"));
        vecs.push_back(mk(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu"));
        vecs.push_back(mk(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2"));
        vecs.push_back(mk(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2"));
        vecs.push_back(mk(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_7_m2"));
        vecs.push_back(mk(REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 34, "rem_7_m2"));
        vecs.push_back(mk(DIVU,   32'd100,      32'd7,        32'd14,       34, "divu_100_7"));
        vecs.push_back(mk(REMU,   32'd100,      32'd7,        32'd2,        34, "remu_100_7"));
        vecs.push_back(mk(DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, "divu_max_1"));
        vecs.push_back(mk(DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, "divu_no_ovf"));
        vecs.push_back(mk(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_by0"));
        vecs.push_back(mk(REM,    32'd5,        32'd0,        32'd5,        1,  "rem_by0"));
        vecs.push_back(mk(DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0"));
        vecs.push_back(mk(REMU,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  "remu_by0"));
        vecs.push_back(mk(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"));
        vecs.push_back(mk(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf"));

        bus.start_i   = 1'b0;
        bus.funct3_i  = 3'b000;
        bus.op_a_i    = '0;
        bus.op_b_i    = '0;
        bus.rd_addr_i = '0;
        bus.flush_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_valid",  32'(bus.valid_o),   32'd0);
        chk("reset_busy",   32'(bus.busy_o),    32'd0);
        chk("reset_stall",  32'(bus.stall_e_o), 32'd0);
        chk("reset_result", bus.result_o,       32'd0);
        chk("reset_rd",     32'(bus.rd_addr_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table of directed vectors
        foreach (vecs[i]) begin
            apply(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat, vecs[i].name);
            @(negedge clk);
        end

        // Flush during DIVU at E0+10, restart at E0+11
        bus.start_i = 1'b1; bus.funct3_i = DIVU; bus.op_a_i = 32'd1000; bus.op_b_i = 32'd3;
        bus.rd_addr_i = 5'd9;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        chk("flush_busy_before", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_busy_after",  32'(bus.busy_o),  32'd0);
        chk("flush_valid_after", 32'(bus.valid_o), 32'd0);
        chk("flush_no_early_valid", 32'(seen), 32'd0);
        apply(DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 34, "flush_restart");

        // Flush and start in the same cycle: no accept
        @(negedge clk);
        bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = MUL;
        bus.op_a_i = 32'd2; bus.op_b_i = 32'd2; bus.rd_addr_i = 5'd11;
        #1 chk("flush_start_stall", 32'(bus.stall_e_o), 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        chk("flush_start_busy", 32'(bus.busy_o), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        chk("flush_start_no_valid", 32'(seen), 32'd0);

        // Back-to-back: start held through DONE; operands changed while busy
        bus.start_i = 1'b1; bus.funct3_i = MUL; bus.op_a_i = 32'd6; bus.op_b_i = 32'd7;
        bus.rd_addr_i = 5'd3;
        @(posedge clk);
        #1;
        bus.op_a_i = 32'd3; bus.op_b_i = 32'd4; bus.rd_addr_i = 5'd4;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.valid_o) begin lat = k; break; end
        end
        chk("b2b_first_latency", 32'(lat), 32'd34);
        chk("b2b_first_result",  bus.result_o, 32'd42);
        chk("b2b_first_rd",      32'(bus.rd_addr_o), 32'd3);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.valid_o) begin lat = k; break; end
        end
        chk("b2b_second_latency", 32'(lat), 32'd34);
        chk("b2b_second_result",  bus.result_o, 32'd12);
        chk("b2b_second_rd",      32'(bus.rd_addr_o), 32'd4);

        // Asynchronous reset in the middle of a MUL
        @(negedge clk);
        bus.start_i = 1'b1; bus.funct3_i = MUL; bus.op_a_i = 32'h1234; bus.op_b_i = 32'h5678;
        bus.rd_addr_i = 5'd7;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid",  32'(bus.valid_o),   32'd0);
        chk("midrst_busy",   32'(bus.busy_o),    32'd0);
        chk("midrst_stall",  32'(bus.stall_e_o), 32'd0);
        chk("midrst_result", bus.result_o,       32'd0);
        chk("midrst_rd",     32'(bus.rd_addr_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid_o || bus.busy_o) seen = 1'b1;
        end
        chk("midrst_idle_after", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_muldiv_seq
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer, placed beside the execute stage ALU. It accepts one M-extension operation from execute and holds execute with a stall while it iterates. It returns a single-cycle result strobe, which execute muxes into the ALU-result path toward EX/MEM. One operation is in flight at a time, and it can be aborted by a pipeline flush.

Parameters:
DATA_WIDTH, 32 (`DATA_WIDTH), operand/result width; the iteration count equals DATA_WIDTH.
REG_ADDR_WIDTH, 5 (`REG_ADDR_WIDTH), destination register tag width.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_i  input  1  request from execute; accepted only in IDLE or DONE.
funct3_i  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a_i  input  DATA_WIDTH  rs1 operand (forwarded value).
op_b_i  input  DATA_WIDTH  rs2 operand (forwarded value).
rd_addr_i  input  REG_ADDR_WIDTH  destination tag.
flush_i  input  1  abort from the hazard unit.
busy_o  output  1  state is not IDLE/DONE.
stall_e_o  output  1  execute-stage stall request.
valid_o  output  1  one-cycle result strobe.
result_o  output  DATA_WIDTH  result; valid only while valid_o=1.
rd_addr_o  output  REG_ADDR_WIDTH  latched destination tag.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs and internal registers are 0 immediately. This holds mid-operation too; no residual valid_o after reset release.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept: start_i=1 in IDLE or DONE at edge E0.
  - Operands, funct3 and rd are latched at E0.
  - Operands are converted to magnitudes by signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned; MUL/DIV/REM signed.
  - Counter is loaded with DATA_WIDTH-1.
- MUL: one shift-add per cycle into a 2*DATA_WIDTH accumulator for DATA_WIDTH cycles. Leaves state when counter==0.
- DIV: one restoring-subtract step per cycle for DATA_WIDTH cycles, producing quotient and remainder magnitudes.
- FIX (1 cycle):
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Output is selected: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*.
- DONE (1 cycle): valid_o=1, result_o and rd_addr_o valid. Next state is IDLE, or MUL/DIV if start_i=1 (back-to-back accept).
- Latency for a normal op: MUL/DIV in cycles E0+1..E0+32, FIX at E0+33, valid_o at cycle E0+34.
- Special cases skip iteration, going E0 → DONE so valid_o is at cycle E0+1:
  - Divide by zero: DIV/DIVU q=all ones; REM/REMU r=op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV q=0x80000000; REM r=0.
- Stall: stall_e_o = (start_i & (IDLE|DONE) & ~flush_i) | busy_o. It drops in the DONE cycle so execute captures the result and advances.
- Flush: flush_i=1 in any state forces IDLE at the next edge, and valid_o is never raised for the aborted op.
  - flush_i has priority over a simultaneous start_i (no accept).
  - flush_i in DONE still lets valid_o=1 show that cycle; the consumer gates it with the flush.
- start_i while busy_o=1 is ignored; operands are not re-latched.
- result_o/rd_addr_o hold their last values outside DONE, but are defined only while valid_o=1.

Decomposition:
- New header common/muldiv_defines.svh holds:
  - the funct3 constants (`MD_MUL … `MD_REMU);
  - typedef enum muldiv_state_e {IDLE, MUL, DIV, FIX, DONE}.
- One natural combinational sub-module, muldiv_step: a single shift-add / restoring-subtract iteration (acc, divisor, mode) → next acc.
- Sign conversion, FIX and the FSM stay in muldiv_seq.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (-3) → result_o=0xFFFFFFEB, valid_o exactly at cycle E0+34, stall_e_o high from the start cycle through E0+33, low at E0+34.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7)/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
4. DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Each gives valid_o at E0+1.
5. DIVU started, flush_i at E0+10 → busy_o=0 at E0+11, no valid_o ever. A start_i at E0+11 is accepted and completes normally; flush_i and start_i in the same cycle → no accept.
6. Back-to-back: start_i held during DONE with MUL 3×4 → first valid_o, second op accepted that edge, result 12 at +34. rst pulsed at E0+5 of a MUL → all outputs 0 asynchronously, IDLE after release, no valid_o.
